// File: rtl/ppumc_arb_if.sv
// Bundle of the render port, host port and ppumc-side signals around ppumc_arb.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface ppumc_arb_if #(
  parameter int ADDR_W = 14
);
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_gnt;
  logic              r_vld;
  logic [7:0]        r_data;

  logic              h_req;
  logic              h_wr;
  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_wdata;
  logic              h_busy;
  logic              h_ack;
  logic [7:0]        h_rdata;

  logic [ADDR_W-1:0] m_a;
  logic              m_wr;
  logic [7:0]        m_dout;
  logic [7:0]        m_din;

  modport slave (
    input  r_req, r_addr, h_req, h_wr, h_addr, h_wdata, m_din,
    output r_gnt, r_vld, r_data, h_busy, h_ack, h_rdata, m_a, m_wr, m_dout
  );

  modport master (
    output r_req, r_addr, h_req, h_wr, h_addr, h_wdata, m_din,
    input  r_gnt, r_vld, r_data, h_busy, h_ack, h_rdata, m_a, m_wr, m_dout
  );
endinterface

// File: rtl/ppumc_arb.sv
// Shares the single-ported ppumc between the render fetch port (priority) and a
// host req/ack port, with a wait counter that forces one host slot under starvation.
module ppumc_arb #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  ppumc_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PEND, ISSUED, ACK} state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_slot;
  logic              r_vld_q;
  logic              h_ack_q;
  logic [7:0]        h_rdata_q;

  // The host wins a slot when the render port is quiet or has starved it long enough.
  assign host_slot = (state == PEND) && (!bus.r_req || (wait_cnt == WAIT_MAX));

  assign bus.r_gnt   = bus.r_req && !host_slot;
  assign bus.m_a     = host_slot ? host_addr : bus.r_addr;
  assign bus.m_wr    = host_slot && host_wr;
  assign bus.m_dout  = host_wdata;
  assign bus.r_vld   = r_vld_q;
  assign bus.r_data  = bus.m_din;
  assign bus.h_busy  = (state != IDLE);
  assign bus.h_ack   = h_ack_q;
  assign bus.h_rdata = h_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      host_wr    <= 1'b0;
      host_addr  <= '0;
      host_wdata <= '0;
      r_vld_q    <= 1'b0;
      h_ack_q    <= 1'b0;
      h_rdata_q  <= '0;
    end else begin
      r_vld_q <= bus.r_gnt;
      h_ack_q <= (state == ISSUED);
      case (state)
        IDLE: begin
          if (bus.h_req) begin
            host_wr    <= bus.h_wr;
            host_addr  <= bus.h_addr;
            host_wdata <= bus.h_wdata;
            wait_cnt   <= '0;
            state      <= PEND;
          end
        end
        PEND: begin
          if (host_slot) begin
            state <= ISSUED;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ISSUED: begin
          // Read data for the address issued last cycle is on m_din now.
          if (!host_wr) h_rdata_q <= bus.m_din;
          state <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppumc_arb.sv
// Directed bench for ppumc_arb: vector table for single-cycle behaviour plus
// hand-written sequences for starvation, reset mid-access and the MAX_WAIT=0 variant.
module tb_ppumc_arb;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ppumc_arb_if #(.ADDR_W(14)) bus ();
  ppumc_arb_if #(.ADDR_W(14)) bus0 ();

  ppumc_arb #(.ADDR_W(14), .MAX_WAIT(8), .WAIT_W(4)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  ppumc_arb #(.ADDR_W(14), .MAX_WAIT(0), .WAIT_W(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory models, one per arbiter instance.
  logic [7:0] mem  [16384];
  logic [7:0] mem0 [16384];

  always @(posedge clk) begin
    if (bus.m_wr) mem[bus.m_a] <= bus.m_dout;
    bus.m_din <= mem[bus.m_a];
  end

  always @(posedge clk) begin
    if (bus0.m_wr) mem0[bus0.m_a] <= bus0.m_dout;
    bus0.m_din <= mem0[bus0.m_a];
  end

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r_req;
    logic [13:0] r_addr;
    logic        h_req;
    logic        h_wr;
    logic [13:0] h_addr;
    logic [7:0]  h_wdata;
    logic        e_gnt;
    logic        e_vld;
    logic        e_busy;
    logic        e_ack;
    logic        e_wr;
    logic [13:0] e_a;
    logic        c_rdata;
    logic [7:0]  e_rdata;
    logic        c_hrdata;
    logic [7:0]  e_hrdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rq, input logic [13:0] ra, input logic hq, input logic hw,
    input logic [13:0] ha, input logic [7:0] hd,
    input logic eg, input logic ev, input logic eb, input logic ek, input logic ew,
    input logic [13:0] ea, input logic crd, input logic [7:0] erd,
    input logic chr, input logic [7:0] ehr);
    vec_t v;
    v.r_req = rq; v.r_addr = ra; v.h_req = hq; v.h_wr = hw; v.h_addr = ha; v.h_wdata = hd;
    v.e_gnt = eg; v.e_vld = ev; v.e_busy = eb; v.e_ack = ek; v.e_wr = ew; v.e_a = ea;
    v.c_rdata = crd; v.e_rdata = erd; v.c_hrdata = chr; v.e_hrdata = ehr;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.r_req = 0; bus.r_addr = '0; bus.h_req = 0; bus.h_wr = 0; bus.h_addr = '0; bus.h_wdata = '0;
    bus0.r_req = 0; bus0.r_addr = '0; bus0.h_req = 0; bus0.h_wr = 0; bus0.h_addr = '0; bus0.h_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_rd(input string name, input logic [13:0] a, input logic [7:0] exp);
    int n;
    bus.h_req = 1; bus.h_wr = 0; bus.h_addr = a;
    step();
    bus.h_req = 0;
    n = 0;
    #3;
    while (!bus.h_ack && n < 40) begin
      @(posedge clk);
      #4;
      n++;
    end
    check({name, "_ack"}, 32'(bus.h_ack), 32'(1));
    check({name, "_rdata"}, 32'(bus.h_rdata), 32'(exp));
    step();
  endtask

  logic [13:0] next_addr;
  logic [13:0] prev_addr;
  logic        prev_vld;
  logic        exp_gnt;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]  = pat(14'(i));
      mem0[i] = pat(14'(i));
    end
    mem[14'h2100] = 8'h11;

    rst = 1'b0;
    idle_inputs();
    step();
    step();
    // Reset state
    check("rst_r_vld",   32'(bus.r_vld),   32'(0));
    check("rst_h_ack",   32'(bus.h_ack),   32'(0));
    check("rst_h_rdata", 32'(bus.h_rdata), 32'(0));
    check("rst_h_busy",  32'(bus.h_busy),  32'(0));
    check("rst_m_wr",    32'(bus.m_wr),    32'(0));
    check("rst_m_a",     32'(bus.m_a),     32'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Host write then read of 0x2005 with render idle; second h_req in PEND and ACK ignored.
    vecs.push_back(mk(0, 0, 1, 1, 14'h2005, 8'hA5, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 1, 0, 1, 14'h2005, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 1, 0, 0, 14'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 1, 1, 0, 14'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 14'h2005, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 14'h1234, 8'hFF, 0, 0, 1, 0, 0, 14'h2005, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 1, 0, 0, 14'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 14'h1234, 8'hFF, 0, 0, 1, 1, 0, 14'h0000, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 0, 14'h0000, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 1, 8'hA5));
    // Render stream 0x0000..0x0007, data one cycle after each grant.
    for (int i = 0; i <= 8; i++) begin
      vecs.push_back(mk(i < 8, (i < 8) ? 14'(i) : 14'h0, 0, 0, 14'h0, 8'h00,
                        i < 8, i > 0, 0, 0, 0, (i < 8) ? 14'(i) : 14'h0,
                        i > 0, pat(14'(i - 1)), 0, 0));
    end

    foreach (vecs[k]) begin
      bus.r_req   = vecs[k].r_req;
      bus.r_addr  = vecs[k].r_addr;
      bus.h_req   = vecs[k].h_req;
      bus.h_wr    = vecs[k].h_wr;
      bus.h_addr  = vecs[k].h_addr;
      bus.h_wdata = vecs[k].h_wdata;
      #4;
      check($sformatf("v%0d_r_gnt", k),  32'(bus.r_gnt),  32'(vecs[k].e_gnt));
      check($sformatf("v%0d_r_vld", k),  32'(bus.r_vld),  32'(vecs[k].e_vld));
      check($sformatf("v%0d_h_busy", k), 32'(bus.h_busy), 32'(vecs[k].e_busy));
      check($sformatf("v%0d_h_ack", k),  32'(bus.h_ack),  32'(vecs[k].e_ack));
      check($sformatf("v%0d_m_wr", k),   32'(bus.m_wr),   32'(vecs[k].e_wr));
      check($sformatf("v%0d_m_a", k),    32'(bus.m_a),    32'(vecs[k].e_a));
      if (vecs[k].c_rdata)
        check($sformatf("v%0d_r_data", k), 32'(bus.r_data), 32'(vecs[k].e_rdata));
      if (vecs[k].c_hrdata)
        check($sformatf("v%0d_h_rdata", k), 32'(bus.h_rdata), 32'(vecs[k].e_hrdata));
      step();
    end
    idle_inputs();
    step();

    // Starvation guard: host read of 0x3F00 under continuous rendering.
    next_addr = 14'h0100;
    prev_vld  = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 16; c++) begin
      bus.r_req  = 1;
      bus.r_addr = next_addr;
      bus.h_req  = (c == 0);
      bus.h_wr   = 0;
      bus.h_addr = 14'h3F00;
      exp_gnt    = (c != 9);
      #4;
      check($sformatf("starve%0d_r_gnt", c),  32'(bus.r_gnt),  32'(exp_gnt));
      check($sformatf("starve%0d_r_vld", c),  32'(bus.r_vld),  32'(prev_vld));
      if (prev_vld)
        check($sformatf("starve%0d_r_data", c), 32'(bus.r_data), 32'(pat(prev_addr)));
      check($sformatf("starve%0d_h_busy", c), 32'(bus.h_busy), 32'(c >= 1 && c <= 11));
      check($sformatf("starve%0d_h_ack", c),  32'(bus.h_ack),  32'(c == 11));
      if (c == 9) check("starve_host_m_a", 32'(bus.m_a), 32'(14'h3F00));
      if (c == 11) check("starve_h_rdata", 32'(bus.h_rdata), 32'(pat(14'h3F00)));
      prev_vld  = exp_gnt;
      prev_addr = next_addr;
      if (exp_gnt) next_addr = next_addr + 14'd1;
      step();
    end
    idle_inputs();
    step();

    // Reset while a write to 0x2100 sits in PEND behind rendering.
    bus.r_req = 1; bus.r_addr = 14'h0200;
    bus.h_req = 1; bus.h_wr = 1; bus.h_addr = 14'h2100; bus.h_wdata = 8'h77;
    step();
    bus.h_req = 0;
    #2;
    check("midrst_pend_busy", 32'(bus.h_busy), 32'(1));
    rst = 1'b0;
    #1;
    check("midrst_h_busy", 32'(bus.h_busy), 32'(0));
    check("midrst_m_wr",   32'(bus.m_wr),   32'(0));
    check("midrst_h_ack",  32'(bus.h_ack),  32'(0));
    bus.r_req = 0;
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      #3;
      check($sformatf("postrst%0d_m_wr", c),  32'(bus.m_wr),  32'(0));
      check($sformatf("postrst%0d_h_ack", c), 32'(bus.h_ack), 32'(0));
      step();
    end
    host_rd("postrst_rd_2100", 14'h2100, 8'h11);
    host_rd("rd_2005", 14'h2005, 8'hA5);

    // MAX_WAIT=0 instance: host read of 0x0020 wins the first PEND cycle.
    for (int c = 0; c < 5; c++) begin
      bus0.r_req  = 1;
      bus0.r_addr = 14'h0010;
      bus0.h_req  = (c == 0);
      bus0.h_wr   = 0;
      bus0.h_addr = 14'h0020;
      #4;
      check($sformatf("mw0_%0d_r_gnt", c), 32'(bus0.r_gnt), 32'(c != 1));
      check($sformatf("mw0_%0d_h_ack", c), 32'(bus0.h_ack), 32'(c == 3));
      if (c == 1) check("mw0_host_m_a", 32'(bus0.m_a), 32'(14'h0020));
      if (c == 3) check("mw0_h_rdata", 32'(bus0.h_rdata), 32'(pat(14'h0020)));
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppumc_arb.md
Name: ppumc_arb

Overview:
- Arbiter and sequencer for the single-ported PPU memory controller (ppumc, 14-bit address, synchronous read with 1-cycle latency).
- Shares ppumc between two requesters:
  - the PPU render fetch port, which has priority;
  - the host port, used by the debugger and later by CPU $2007 accesses, with a req/ack handshake.
- A starvation counter guarantees host progress during continuous rendering.
- Sits between ppu/dbg and ppumc in the top level, replacing the direct dbg-to-ppumc wiring.

Parameters:
- ADDR_W, 14, ppumc address width.
- MAX_WAIT, 8, number of denied host cycles after which the host is forced one slot (0 = host always wins).
- WAIT_W, 4, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset (0 = reset).
- r_req  in  1  render read request (level; one read per granted cycle).
- r_addr  in  ADDR_W  render read address.
- r_gnt  out  1  render request accepted this cycle (combinational).
- r_vld  out  1  render read data valid (cycle after r_gnt).
- r_data  out  8  render read data.
- h_req  in  1  host request strobe.
- h_wr  in  1  host write (1) / read (0), sampled with h_req.
- h_addr  in  ADDR_W  host address, sampled with h_req.
- h_wdata  in  8  host write data, sampled with h_req.
- h_busy  out  1  host request outstanding; h_req ignored while high.
- h_ack  out  1  one-cycle completion pulse.
- h_rdata  out  8  host read data, valid with h_ack, held until the next host read completes.
- m_a  out  ADDR_W  ppumc address.
- m_wr  out  1  ppumc write enable.
- m_dout  out  8  ppumc write data.
- m_din  in  8  ppumc read data (valid 1 cycle after address).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, wait_cnt=0.
  - Registered outputs: r_vld=0, h_ack=0, h_rdata=0.
  - Combinational outputs follow from IDLE: h_busy=0, m_wr=0, m_a=0 when no render request.
  - Any outstanding host access is dropped without ack; no partial write is issued after reset release.
- Host FSM states: IDLE, PEND, ISSUED, ACK.
  - IDLE: h_req=1 latches h_wr/h_addr/h_wdata, clears wait_cnt, goes to PEND. h_busy is high from the next cycle.
  - PEND: host_slot = (r_req==0) || (wait_cnt==MAX_WAIT).
    - host_slot=1: drive m_a=addr, m_wr=wr, m_dout=wdata; go to ISSUED.
    - Otherwise: wait_cnt increments, saturating at MAX_WAIT.
  - ISSUED: for reads, capture m_din into h_rdata. Go to ACK.
  - ACK: h_ack=1 for exactly one cycle; go to IDLE (h_busy=0 in ACK's following cycle).
  - Latency with an idle render port: h_req at T, issue at T+1, capture at T+2, h_ack at T+3.
  - h_req in the ACK cycle is ignored; h_busy covers PEND, ISSUED and ACK.
- Render path:
  - r_gnt = r_req && !(state==PEND && host_slot).
  - When r_gnt=1: m_a=r_addr, m_wr=0.
  - r_vld is registered r_gnt; r_data = m_din (passthrough) in the r_vld cycle.
  - A denied render request must be held by the requester; the arbiter has no render queue.
- Slot rules:
  - Exactly one access per cycle; m_wr=1 only in a host write issue cycle.
  - No access in a cycle: m_a holds r_addr, m_wr=0.
  - Render and host issue never coincide.
- MAX_WAIT=0: the host issues in the first PEND cycle regardless of r_req.
- Write-then-read ordering: a host read following a host write to the same address returns the written value; each access completes before the next is accepted.
- Address: passed through unmodified, width ADDR_W; no mirroring in this block.

Test Plan:
- Host write, render idle: rst low then high; h_req with wr=1, addr=0x2005, wdata=0xA5 at T. Required: m_wr=1 and m_a=0x2005 at T+1; h_ack at T+3. A subsequent read of 0x2005 returns h_rdata=0xA5 with its h_ack.
- Render stream: r_req held high with addresses 0x0000..0x0007, no host traffic. Required: r_gnt=1 every cycle; r_vld one cycle later; r_data matches the preloaded pattern, 8 consecutive beats.
- Starvation guard (MAX_WAIT=8): host read of 0x3F00 issued during a continuous r_req. Required: r_gnt=0 for exactly one cycle after 8 PEND cycles; the host access occupies that slot; h_ack 2 cycles later; rendering resumes with no lost beats once the requester holds its request.
- Busy protocol: second h_req pulsed while h_busy=1. Required: ignored; no second access; only one h_ack.
- Reset mid-operation: assert rst=0 while in PEND with a write pending to 0x2100, preloaded 0x11. Required: h_busy=0 and m_wr=0 immediately; no h_ack; 0x2100 still reads 0x11 after release.
- MAX_WAIT=0 variant: host request during a continuous r_req. Required: host issues in the first PEND cycle; r_gnt=0 in that cycle only.
